// File: rtl/sevenseg_pkg.sv
// Shared constants, converter state type and helpers for the scanned BCD
// seven-segment display driver.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // Active-low cathode patterns, bit order {a,b,c,d,e,f,g}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100   // 9
  };

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_BLANK;
    if (nib <= 4'd9) begin
      seg = SEG_DIGIT[nib];
    end
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_scan_bcd_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with a valid/ready input
// handshake; one input bit is consumed per SHIFT cycle.
module bin2bcd_seq
  import sevenseg_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int VALUE_W = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value_in,
  input  logic                  value_valid,
  output logic                  value_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic                  done
);

  localparam int          CNT_W     = $clog2(VALUE_W + 1);
  localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

  // Handshake: a value is taken on any clock edge where value_valid and
  // value_ready are both high; ready is high only in IDLE, and valid seen
  // while ready is low has no effect.
  conv_state_e          state_q, state_d;
  logic [VALUE_W-1:0]   shreg_q, shreg_d;
  logic [4*DIGITS-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic [4*DIGITS-1:0]  adj;
  logic [63:0]          value_ext;

  assign value_ext = 64'(value_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (value_valid) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    value_ready = (state_q == IDLE);
    done        = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
    end
  end

  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    shreg_d    = shreg_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    case (state_q)
      IDLE: begin
        if (value_valid) begin
          shreg_d    = value_in;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (value_ext >= OVF_LIMIT);
        end
      end
      SHIFT: begin
        // Bits leaving the top nibble are dropped; overflow is flagged separately.
        acc_d   = {adj[4*DIGITS-2:0], shreg_q[VALUE_W-1]};
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  assign bcd = acc_q;
  assign ovf = ovf_pend_q;

endmodule

// File: rtl/sevenseg_scan_bcd.sv
// Multiplexed common-anode seven-segment driver: converts a binary value to
// BCD and scans the digits with leading-zero blanking and decimal points.
module sevenseg_scan_bcd
  import sevenseg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int VALUE_W   = 14,
  parameter int REFRESH_W = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [VALUE_W-1:0]  value_in,
  input  logic                value_valid,
  output logic                value_ready,
  input  logic                blank_lz_en,
  input  logic [DIGITS-1:0]   dp_mask,
  output logic [DIGITS-1:0]   anode_select,
  output logic [6:0]          LED_out,
  output logic                dp_out,
  output logic                overflow
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0]  conv_bcd;
  logic                 conv_ovf;
  logic                 conv_done;

  logic [REFRESH_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 started_q, started_d;
  logic [4*DIGITS-1:0]  disp_q, disp_d;
  logic                 ovf_q, ovf_d;
  logic [DIGITS-1:0]    anode_q, anode_d;
  logic [6:0]           led_q, led_d;
  logic                 dp_q, dp_d;

  logic                 wrap;
  logic [DIGITS-1:0]    lead_zero;
  logic                 zero_run;
  logic [3:0]           nib;
  logic                 pos_blank;
  logic                 dp_bit;
  logic [DIGITS-1:0]    anode_sel;
  logic [6:0]           seg;

  bin2bcd_seq #(
    .DIGITS  (DIGITS),
    .VALUE_W (VALUE_W)
  ) u_conv (
    .clk         (clk),
    .rst         (reset),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .bcd         (conv_bcd),
    .ovf         (conv_ovf),
    .done        (conv_done)
  );

  always_comb begin
    presc_d   = presc_q + REFRESH_W'(1);
    wrap      = &presc_q;
    idx_d     = idx_q;
    started_d = started_q | wrap;
    if (wrap) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    // The display only moves on the commit pulse, so a conversion in flight
    // never shows up as a partial value.
    disp_d = conv_done ? conv_bcd : disp_q;
    ovf_d  = conv_done ? conv_ovf : ovf_q;
  end

  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (disp_q[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_run;
    end
  end

  // Scan index 0 is the leftmost digit, i.e. digit position DIGITS-1.
  always_comb begin
    nib       = 4'd0;
    pos_blank = 1'b0;
    dp_bit    = 1'b0;
    anode_sel = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(DIGITS - 1 - i)) begin
        nib          = disp_q[4*i +: 4];
        pos_blank    = lead_zero[i] && (i != 0);
        dp_bit       = dp_mask[i];
        anode_sel[i] = 1'b0;
      end
    end
  end

  always_comb begin
    if (ovf_q) begin
      seg = SEG_DASH;
    end else if (blank_lz_en && pos_blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = seg_decode(nib);
    end
    anode_d = started_q ? anode_sel : '1;
    led_d   = started_q ? seg : SEG_BLANK;
    dp_d    = started_q ? ~dp_bit : 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      idx_q     <= '0;
      started_q <= 1'b0;
      disp_q    <= '0;
      ovf_q     <= 1'b0;
      anode_q   <= '1;
      led_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      started_q <= started_d;
      disp_q    <= disp_d;
      ovf_q     <= ovf_d;
      anode_q   <= anode_d;
      led_q     <= led_d;
      dp_q      <= dp_d;
    end
  end

  assign anode_select = anode_q;
  assign LED_out      = led_q;
  assign dp_out       = dp_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_sevenseg_scan_bcd.sv
// Bench for sevenseg_scan_bcd: a 4-digit and a 6-digit instance, checked
// against an arithmetic model of what each lit digit should show.
module tb_sevenseg_scan_bcd;

  localparam int D4 = 4;
  localparam int W4 = 14;
  localparam int D6 = 6;
  localparam int W6 = 20;
  localparam int RW = 2;

  localparam logic [6:0] SEG_TAB [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  logic clk = 1'b0;
  logic rst;

  logic [W4-1:0] value_in;
  logic          value_valid;
  logic          value_ready;
  logic          blank_lz_en;
  logic [D4-1:0] dp_mask;
  logic [D4-1:0] anode_select;
  logic [6:0]    led_out;
  logic          dp_out;
  logic          overflow;

  logic [W6-1:0] value_in6;
  logic          value_valid6;
  logic          value_ready6;
  logic          blank_lz_en6;
  logic [D6-1:0] dp_mask6;
  logic [D6-1:0] anode_select6;
  logic [6:0]    led_out6;
  logic          dp_out6;
  logic          overflow6;

  int n_vec = 0;
  int n_err = 0;
  logic [W4-1:0] exp_q[$];
  longint unsigned cur_val;

  always #5 clk = ~clk;

  sevenseg_scan_bcd #(.DIGITS(D4), .VALUE_W(W4), .REFRESH_W(RW)) dut (
    .clk          (clk),
    .reset        (rst),
    .value_in     (value_in),
    .value_valid  (value_valid),
    .value_ready  (value_ready),
    .blank_lz_en  (blank_lz_en),
    .dp_mask      (dp_mask),
    .anode_select (anode_select),
    .LED_out      (led_out),
    .dp_out       (dp_out),
    .overflow     (overflow)
  );

  sevenseg_scan_bcd #(.DIGITS(D6), .VALUE_W(W6), .REFRESH_W(RW)) dut6 (
    .clk          (clk),
    .reset        (rst),
    .value_in     (value_in6),
    .value_valid  (value_valid6),
    .value_ready  (value_ready6),
    .blank_lz_en  (blank_lz_en6),
    .dp_mask      (dp_mask6),
    .anode_select (anode_select6),
    .LED_out      (led_out6),
    .dp_out       (dp_out6),
    .overflow     (overflow6)
  );

  // Reference: what digit position pos of a `digits`-wide display shows for v.
  function automatic logic [6:0] exp_seg(input longint unsigned v, input int pos,
                                         input int digits, input bit blank_en);
    longint unsigned lim;
    longint unsigned p;
    lim = 1;
    p   = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    for (int i = 0; i < pos; i++) p = p * 10;
    if (v >= lim) return 7'b1111110;
    if (blank_en && pos != 0 && v < p) return 7'b1111111;
    return SEG_TAB[int'((v / p) % 10)];
  endfunction

  // Driver for the 4-digit instance; also checks busy length and overflow.
  task automatic send_value(input logic [W4-1:0] v);
    int waited;
    int busy;
    @(negedge clk);
    value_in    = v;
    value_valid = 1'b1;
    waited = 0;
    while (!value_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!value_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_ready_timeout value_ready=%b required 1", value_ready);
      value_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(v);
    @(negedge clk);
    value_valid = 1'b0;
    busy = 0;
    while (!value_ready && busy < 100) begin
      busy++;
      @(negedge clk);
    end
    n_vec++;
    if (busy !== W4 + 1) begin
      n_err++;
      $display("FAIL busy_cycles v=%0d got %0d required %0d", v, busy, W4 + 1);
    end
    cur_val = exp_q.pop_front();
    n_vec++;
    if (overflow !== (cur_val >= 10000)) begin
      n_err++;
      $display("FAIL overflow_flag v=%0d got %b required %b", cur_val, overflow, cur_val >= 10000);
    end
  endtask

  task automatic check_scan(input string tag);
    int waited;
    int prev;
    int pos;
    int zeros;
    logic [D4-1:0] seen;
    waited = 0;
    prev   = -1;
    seen   = '0;
    while (anode_select == 4'b1111 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (anode_select == 4'b1111) begin
      n_vec++; n_err++;
      $display("FAIL %s scan_start anode=%b required one low bit", tag, anode_select);
      return;
    end
    for (int c = 0; c < 3 * D4 * (1 << RW); c++) begin
      @(negedge clk);
      zeros = 0;
      pos   = -1;
      for (int i = 0; i < D4; i++) begin
        if (!anode_select[i]) begin
          zeros++;
          pos = i;
        end
      end
      n_vec++;
      if (zeros != 1) begin
        n_err++;
        $display("FAIL %s anode_onehot got %b required exactly one 0", tag, anode_select);
      end else begin
        seen[pos] = 1'b1;
        n_vec += 3;
        if (led_out !== exp_seg(cur_val, pos, D4, blank_lz_en)) begin
          n_err++;
          $display("FAIL %s segments val=%0d anode=%b got %b required %b", tag, cur_val,
                   anode_select, led_out, exp_seg(cur_val, pos, D4, blank_lz_en));
        end
        if (dp_out !== ~dp_mask[pos]) begin
          n_err++;
          $display("FAIL %s dp anode=%b got %b required %b", tag, anode_select, dp_out, ~dp_mask[pos]);
        end
        if (overflow !== (cur_val >= 10000)) begin
          n_err++;
          $display("FAIL %s overflow got %b required %b", tag, overflow, cur_val >= 10000);
        end
        if (prev >= 0 && pos != prev) begin
          n_vec++;
          if (pos != ((prev == 0) ? D4 - 1 : prev - 1)) begin
            n_err++;
            $display("FAIL %s scan_order got digit %0d after %0d", tag, pos, prev);
          end
        end
        prev = pos;
      end
    end
    n_vec++;
    if (seen !== 4'b1111) begin
      n_err++;
      $display("FAIL %s digits_seen got %b required 1111", tag, seen);
    end
  endtask

  task automatic test_reset;
    rst          = 1'b1;
    value_in     = '0;
    value_valid  = 1'b0;
    blank_lz_en  = 1'b0;
    dp_mask      = '0;
    value_in6    = '0;
    value_valid6 = 1'b0;
    blank_lz_en6 = 1'b0;
    dp_mask6     = '0;
    cur_val      = 0;
    repeat (3) @(negedge clk);
    n_vec += 6;
    if (anode_select !== 4'b1111) begin n_err++; $display("FAIL rst_anode got %b required 1111", anode_select); end
    if (led_out !== 7'b1111111) begin n_err++; $display("FAIL rst_led got %b required 1111111", led_out); end
    if (dp_out !== 1'b1) begin n_err++; $display("FAIL rst_dp got %b required 1", dp_out); end
    if (value_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b required 1", value_ready); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b required 0", overflow); end
    if (anode_select6 !== 6'b111111) begin n_err++; $display("FAIL rst_anode6 got %b required 111111", anode_select6); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (anode_select !== 4'b1111) begin
      n_err++;
      $display("FAIL prewrap_anode got %b required 1111", anode_select);
    end
  endtask

  task automatic test_1234;
    blank_lz_en = 1'b0;
    dp_mask     = 4'b0000;
    send_value(14'd1234);
    check_scan("v1234");
  endtask

  task automatic test_blank_dp;
    blank_lz_en = 1'b1;
    dp_mask     = 4'b0100;
    send_value(14'd7);
    check_scan("v7_blank_dp");
  endtask

  task automatic test_overflow;
    blank_lz_en = 1'b1;
    dp_mask     = 4'b0001;
    send_value(14'd10000);
    check_scan("v10000");
    send_value(14'd0);
    check_scan("v0_blank");
    blank_lz_en = 1'b0;
    check_scan("v0_noblank");
  endtask

  task automatic test_back_to_back;
    int busy;
    int pos;
    blank_lz_en = 1'b0;
    dp_mask     = 4'b1000;
    send_value(14'd5);
    send_value(14'd9);
    check_scan("b2b_9");
    @(negedge clk);
    value_in    = 14'd9999;
    value_valid = 1'b1;
    n_vec++;
    if (value_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_before_9999 got %b required 1", value_ready);
    end
    @(posedge clk);
    exp_q.push_back(14'd9999);
    @(negedge clk);
    value_valid = 1'b0;
    busy = 0;
    while (!value_ready && busy < 100) begin
      if (busy == 3) begin value_in = 14'd42; value_valid = 1'b1; end
      if (busy == 6) value_valid = 1'b0;
      pos = -1;
      for (int i = 0; i < D4; i++) if (!anode_select[i]) pos = i;
      if (pos >= 0) begin
        n_vec++;
        if (led_out !== exp_seg(cur_val, pos, D4, blank_lz_en)) begin
          n_err++;
          $display("FAIL hold_during_shift anode=%b got %b required %b", anode_select, led_out,
                   exp_seg(cur_val, pos, D4, blank_lz_en));
        end
      end
      busy++;
      @(negedge clk);
    end
    value_valid = 1'b0;
    n_vec++;
    if (busy !== W4 + 1) begin
      n_err++;
      $display("FAIL busy_9999 got %0d required %0d", busy, W4 + 1);
    end
    cur_val = exp_q.pop_front();
    repeat (4) @(negedge clk);
    n_vec++;
    if (value_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ignored_42_ready got %b required 1", value_ready);
    end
    check_scan("v9999_ignore42");
  endtask

  task automatic test_reset_mid_shift;
    blank_lz_en = 1'b0;
    @(negedge clk);
    value_in    = 14'd5678;
    value_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    value_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec += 5;
    if (anode_select !== 4'b1111) begin n_err++; $display("FAIL async_rst_anode got %b required 1111", anode_select); end
    if (led_out !== 7'b1111111) begin n_err++; $display("FAIL async_rst_led got %b required 1111111", led_out); end
    if (dp_out !== 1'b1) begin n_err++; $display("FAIL async_rst_dp got %b required 1", dp_out); end
    if (value_ready !== 1'b1) begin n_err++; $display("FAIL async_rst_ready got %b required 1", value_ready); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL async_rst_ovf got %b required 0", overflow); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    cur_val = 0;
    @(negedge clk);
    n_vec++;
    if (anode_select !== 4'b1111) begin
      n_err++;
      $display("FAIL mid_rst_prewrap_anode got %b required 1111", anode_select);
    end
    repeat (W4 + 5) @(negedge clk);
    n_vec += 2;
    if (value_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready got %b required 1", value_ready); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_rst_ovf got %b required 0", overflow); end
    check_scan("after_mid_rst");
  endtask

  task automatic test_random;
    logic [W4-1:0] v;
    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 3))
        0:       v = W4'($urandom_range(0, 9));
        1:       v = W4'($urandom_range(10, 999));
        2:       v = W4'($urandom_range(1000, 9999));
        default: v = W4'($urandom_range(0, 16383));
      endcase
      blank_lz_en = 1'($urandom_range(0, 1));
      dp_mask     = D4'($urandom_range(0, 15));
      send_value(v);
      check_scan("random");
    end
  endtask

  task automatic test_six_digits;
    longint unsigned vals [3];
    int waited;
    int busy;
    int prev;
    int pos;
    int zeros;
    bit wrap_seen;
    vals[0] = 999999;
    vals[1] = 1000000;
    vals[2] = longint'($urandom_range(0, 999999));
    for (int k = 0; k < 3; k++) begin
      blank_lz_en6 = (k == 2);
      dp_mask6     = D6'($urandom_range(0, 63));
      @(negedge clk);
      value_in6    = W6'(vals[k]);
      value_valid6 = 1'b1;
      waited = 0;
      while (!value_ready6 && waited < 100) begin @(negedge clk); waited++; end
      @(posedge clk);
      @(negedge clk);
      value_valid6 = 1'b0;
      busy = 0;
      while (!value_ready6 && busy < 100) begin busy++; @(negedge clk); end
      n_vec += 2;
      if (busy !== W6 + 1) begin
        n_err++;
        $display("FAIL six_busy v=%0d got %0d required %0d", vals[k], busy, W6 + 1);
      end
      if (overflow6 !== (vals[k] >= 1000000)) begin
        n_err++;
        $display("FAIL six_overflow v=%0d got %b required %b", vals[k], overflow6, vals[k] >= 1000000);
      end
      prev = -1;
      wrap_seen = 1'b0;
      for (int c = 0; c < 3 * D6 * (1 << RW); c++) begin
        @(negedge clk);
        zeros = 0;
        pos   = -1;
        for (int i = 0; i < D6; i++) if (!anode_select6[i]) begin zeros++; pos = i; end
        if (zeros == 0 && prev < 0) continue;
        n_vec++;
        if (zeros != 1) begin
          n_err++;
          $display("FAIL six_onehot got %b required exactly one 0", anode_select6);
          continue;
        end
        n_vec += 2;
        if (led_out6 !== exp_seg(vals[k], pos, D6, blank_lz_en6)) begin
          n_err++;
          $display("FAIL six_segments v=%0d anode=%b got %b required %b", vals[k], anode_select6,
                   led_out6, exp_seg(vals[k], pos, D6, blank_lz_en6));
        end
        if (dp_out6 !== ~dp_mask6[pos]) begin
          n_err++;
          $display("FAIL six_dp anode=%b got %b required %b", anode_select6, dp_out6, ~dp_mask6[pos]);
        end
        if (prev >= 0 && pos != prev) begin
          n_vec++;
          if (pos != ((prev == 0) ? D6 - 1 : prev - 1)) begin
            n_err++;
            $display("FAIL six_order got digit %0d after %0d", pos, prev);
          end
          if (prev == 0 && pos == D6 - 1) wrap_seen = 1'b1;
        end
        prev = pos;
      end
      n_vec++;
      if (!wrap_seen) begin
        n_err++;
        $display("FAIL six_index_wrap got no 5->0 wrap required one");
      end
    end
  endtask

  initial begin
    test_reset();
    test_1234();
    test_blank_dp();
    test_overflow();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    test_six_digits();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_bcd.md
Name: sevenseg_scan_bcd

Overview:
- Parametrised successor to the team's 4-digit Basys 3 seven-segment driver.
- Accepts a binary value over a valid/ready handshake and converts it to BCD with a sequential double-dabble engine.
- Time-multiplexes DIGITS common-anode digits with leading-zero blanking, per-digit decimal points and an overflow indication.
- Sits between counter/measurement logic and the board's anode/cathode pins.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8)
VALUE_W, 14, width of binary input value
REFRESH_W, 18, prescaler width; one digit period = 2^REFRESH_W clk cycles (2.6 ms at 100 MHz)

Ports:
clk  input  1  100 MHz system clock
reset  input  1  asynchronous, active-high reset
value_in  input  VALUE_W  unsigned binary value to display
value_valid  input  1  value_in is valid this cycle
value_ready  output  1  block can accept a new value (high only in IDLE)
blank_lz_en  input  1  1 = blank leading zeros
dp_mask  input  DIGITS  bit i lights the decimal point of digit i (digit 0 = rightmost)
anode_select  output  DIGITS  active-low digit enables
LED_out  output  7  active-low cathodes {a,b,c,d,e,f,g}
dp_out  output  1  active-low decimal-point cathode
overflow  output  1  displayed value exceeded 10^DIGITS-1

Behaviour:
- Reset, asynchronous and active-high, applies immediately:
  - anode_select all 1s; LED_out 7'b1111111; dp_out 1; overflow 0; value_ready 1.
  - Display BCD register cleared to 0; prescaler 0; scan index 0; converter in IDLE.
- Converter FSM:
  - IDLE: value_ready=1. A transfer occurs when value_valid && value_ready. On transfer, latch value_in, set ovf_pending = (value_in >= 10^DIGITS), go to SHIFT.
  - SHIFT: value_ready=0. Exactly VALUE_W cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift left one bit, taking the next MSB of the latched value. The BCD accumulator is 4*DIGITS bits; bits shifted out are discarded.
  - DONE: one cycle. Commit the accumulator to the display register and ovf_pending to overflow. Return to IDLE.
  - Latency: a transfer at edge N updates the display register and overflow at edge N+VALUE_W+1. value_ready returns high on that edge.
- value_valid while value_ready=0 is ignored. The producer holds value_in and value_valid until it sees ready.
- The display register keeps its old value throughout a conversion, so no partial values are ever shown.
- Scan:
  - Prescaler increments every cycle. On wrap, the scan index advances.
  - The index wraps DIGITS-1 -> 0, including non-power-of-two DIGITS.
  - Index 0 selects the leftmost (most significant) digit, i.e. anode_select bit DIGITS-1. This matches the existing 0111, 1011, ... ordering.
- Outputs are registered:
  - anode_select, LED_out and dp_out change one cycle after the index changes, always together.
  - Exactly one anode bit is 0 at any time after the first post-reset wrap. Before that wrap, all anode bits are 1.
- Segment selection, highest priority first:
  1. overflow=1: every digit shows a dash (7'b1111110).
  2. blank_lz_en=1 and the digit and all more-significant digits are 0: blank (7'b1111111). The rightmost digit is never blanked, so a value of 0 shows "0".
  3. Otherwise the BCD nibble is decoded with the team digit table. Nibbles above 9 are blank (unreachable).
- dp_out = ~dp_mask[digit] and is not affected by blanking or overflow. dp_mask and blank_lz_en are sampled live each cycle.
- Reset during SHIFT or DONE abandons the conversion. No commit occurs.
- If VALUE_W is too small to reach 10^DIGITS, overflow is constant 0.

Decomposition:
- sevenseg_pkg holds:
  - segment constants SEG_DIGIT[0:9], SEG_BLANK, SEG_DASH;
  - the converter state enum {IDLE, SHIFT, DONE};
  - the function pow10(n) used for the overflow threshold.
- One sub-module, bin2bcd_seq, holds the handshake plus double-dabble FSM. Its outputs are bcd[4*DIGITS-1:0], ovf and a done pulse.
- The top level holds the prescaler, scan index, blanking logic and output registers.

Test Plan:
- Bench parameters are REFRESH_W=2 unless stated. Assert reset for 3 cycles -> anode_select=4'b1111, LED_out=7'b1111111, dp_out=1, value_ready=1, overflow=0.
- Transfer value_in=1234, blank_lz_en=0 -> value_ready low for 15 cycles. Over one scan the digits read "1","2","3","4" (0010010 on anode 1011, etc.).
- value_in=7, blank_lz_en=1, dp_mask=4'b0100 -> three blank digits then "7" (0001111). dp_out=0 only on anode 1011.
- value_in=10000 -> overflow=1 and all four digits show 7'b1111110. A following value_in=0 -> overflow=0 and the display shows "0" with blanking on, "0000" with blanking off.
- Pulse value_valid with 42 during SHIFT of a 9999 conversion -> 42 is ignored and 9999 is displayed. Assert reset mid-SHIFT -> the display shows the reset state and no commit occurs.
- DIGITS=6, VALUE_W=20, value_in=999999 -> anode walks 011111..111110, all digits show "9" (0000100), the index wraps 5->0, and overflow=0.
